// File: rtl/time_seg_595.sv
// time_seg_595: drives the three rightmost digits of a 6-digit common-anode 7-segment
// display through a 74HC595 serial shift chain.
//
// Each display slot lasts SCAN_CYCLES cycles. On each slot tick the block samples one BCD
// digit and builds a 14-bit frame {sel[5:0], seg[7:0]}. It shifts the frame out MSB first
// on ds/shcp, then pulses stcp to latch the frame.
//
// Parameters:
//   CLK_DIV      sys_clk cycles per shcp half-period (>= 1)
//   SCAN_CYCLES  sys_clk cycles per digit slot (> 29*CLK_DIV)
//   BLINK_CYCLES sys_clk cycles per blink half-period while time_max_flag is set
//
// Ports:
//   sys_clk, sys_rst_n             clock and synchronous active-low reset
//   time_1s/time_10s/time_100s     BCD digits (10..15 display a dash)
//   time_max_flag                  blink the display
//   game_over                      light the decimal point on the ones digit
//   shcp, stcp, ds, oe_n           74HC595 shift clock, latch clock, data, output enable
//
// Build option: define TIME_SEG_LZB_EN to blank leading zeros on the hundreds and tens digits.
module time_seg_595 #(
   parameter int unsigned CLK_DIV      = 2,
   parameter int unsigned SCAN_CYCLES  = 50000,
   parameter int unsigned BLINK_CYCLES = 25000000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [3:0] time_1s,
   input  logic [3:0] time_10s,
   input  logic [3:0] time_100s,
   input  logic       time_max_flag,
   input  logic       game_over,
   output logic       shcp,
   output logic       stcp,
   output logic       ds,
   output logic       oe_n
);

   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned SCAN_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StLatch} state_e;

   state_e              r_state, w_state_d;
   logic [SCAN_W-1:0]   r_scan_cnt;
   logic [BLINK_W-1:0]  r_blink_cnt;
   logic                r_blink_on;
   logic [1:0]          r_idx;        // slot index advanced on every tick
   logic [1:0]          r_frame_idx;  // index captured for the frame in flight
   logic [1:0]          w_frame_idx_d;
   logic [13:0]         r_word, w_word_d;
   logic [DIV_W-1:0]    r_div_cnt, w_div_d;
   logic                r_half, w_half_d;  // 0: shcp low half, 1: shcp high half
   logic [3:0]          r_bit_cnt, w_bit_d;
   logic                r_shcp, r_stcp, r_ds, r_oe_n;
   logic                w_shcp_d, w_stcp_d, w_ds_d, w_oe_n_d;
   logic                w_tick;
   logic [3:0]          w_digit;
   logic [6:0]          w_seg_raw;
   logic                w_dp, w_blank;
   logic [7:0]          w_seg;
   logic [5:0]          w_sel;
   logic [13:0]         w_frame;

   assign w_tick = (r_scan_cnt == SCAN_LAST);
   assign shcp   = r_shcp;
   assign stcp   = r_stcp;
   assign ds     = r_ds;
   assign oe_n   = r_oe_n;

   // Slot timing and blink phase run freely, independent of the frame FSM.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_scan_cnt  <= '0;
         r_idx       <= 2'd0;
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else begin
         r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;
         if (w_tick) r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
         if (!time_max_flag) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
         end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   // Frame contents for the captured slot; used only while in StLoad.
   always_comb begin
      unique case (r_frame_idx)
         2'd1:    w_digit = time_10s;
         2'd2:    w_digit = time_100s;
         default: w_digit = time_1s;
      endcase
      case (w_digit)
         4'd0:    w_seg_raw = 7'h40;
         4'd1:    w_seg_raw = 7'h79;
         4'd2:    w_seg_raw = 7'h24;
         4'd3:    w_seg_raw = 7'h30;
         4'd4:    w_seg_raw = 7'h19;
         4'd5:    w_seg_raw = 7'h12;
         4'd6:    w_seg_raw = 7'h02;
         4'd7:    w_seg_raw = 7'h78;
         4'd8:    w_seg_raw = 7'h00;
         4'd9:    w_seg_raw = 7'h10;
         default: w_seg_raw = 7'h3F;  // dash for non-BCD values
      endcase
      w_dp    = ~((r_frame_idx == 2'd0) && game_over);
      w_blank = 1'b0;
`ifdef TIME_SEG_LZB_EN
      if (r_frame_idx == 2'd2 && time_100s == 4'd0) w_blank = 1'b1;
      if (r_frame_idx == 2'd1 && time_100s == 4'd0 && time_10s == 4'd0) w_blank = 1'b1;
`else
      w_blank = 1'b0;
`endif
      w_seg = (!r_blink_on || w_blank) ? 8'hFF : {w_dp, w_seg_raw};
      unique case (r_frame_idx)
         2'd1:    w_sel = 6'b000010;
         2'd2:    w_sel = 6'b000100;
         default: w_sel = 6'b000001;
      endcase
      w_frame = {w_sel, w_seg};
   end

   always_comb begin
      w_state_d     = r_state;
      w_frame_idx_d = r_frame_idx;
      w_word_d      = r_word;
      w_div_d       = r_div_cnt;
      w_half_d      = r_half;
      w_bit_d       = r_bit_cnt;
      w_shcp_d      = 1'b0;
      w_stcp_d      = 1'b0;
      w_ds_d        = 1'b0;
      w_oe_n_d      = r_oe_n;
      case (r_state)
         StIdle: begin
            if (w_tick) begin
               w_state_d     = StLoad;
               w_frame_idx_d = r_idx;
            end
         end
         StLoad: begin
            w_state_d = StShift;
            w_word_d  = w_frame;
            w_div_d   = '0;
            w_half_d  = 1'b0;
            w_bit_d   = 4'd0;
            w_ds_d    = w_frame[13];
         end
         StShift: begin
            w_ds_d   = r_ds;
            w_shcp_d = r_shcp;
            if (r_div_cnt == DIV_LAST) begin
               w_div_d = '0;
               if (!r_half) begin
                  w_half_d = 1'b1;
                  w_shcp_d = 1'b1;
               end else begin
                  w_half_d = 1'b0;
                  w_shcp_d = 1'b0;
                  if (r_bit_cnt == 4'd13) begin
                     w_state_d = StLatch;
                     w_stcp_d  = 1'b1;
                     w_ds_d    = 1'b0;
                  end else begin
                     w_bit_d  = r_bit_cnt + 4'd1;
                     // Rotate rather than shift so every word bit stays live.
                     w_word_d = {r_word[12:0], r_word[13]};
                     w_ds_d   = r_word[12];
                  end
               end
            end else begin
               w_div_d = r_div_cnt + 1'b1;
            end
         end
         StLatch: begin
            if (r_div_cnt == DIV_LAST) begin
               w_state_d = StIdle;
               w_oe_n_d  = 1'b0;
            end else begin
               w_div_d  = r_div_cnt + 1'b1;
               w_stcp_d = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state     <= StIdle;
         r_frame_idx <= 2'd0;
         r_word      <= '0;
         r_div_cnt   <= '0;
         r_half      <= 1'b0;
         r_bit_cnt   <= 4'd0;
         r_shcp      <= 1'b0;
         r_stcp      <= 1'b0;
         r_ds        <= 1'b0;
         r_oe_n      <= 1'b1;
      end else begin
         r_state     <= w_state_d;
         r_frame_idx <= w_frame_idx_d;
         r_word      <= w_word_d;
         r_div_cnt   <= w_div_d;
         r_half      <= w_half_d;
         r_bit_cnt   <= w_bit_d;
         r_shcp      <= w_shcp_d;
         r_stcp      <= w_stcp_d;
         r_ds        <= w_ds_d;
         r_oe_n      <= w_oe_n_d;
      end
   end

endmodule

// File: tb/tb_time_seg_595.sv
module tb_time_seg_595;

   localparam int unsigned CLK_DIV = 2;
   localparam int unsigned SCAN    = 64;
   localparam int unsigned BLINK   = 256;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] t1, t10, t100;
   logic       maxf, gover;
   logic       shcp, stcp, ds, oe_n;

   int checks = 0;
   int errors = 0;

   time_seg_595 #(
      .CLK_DIV     (CLK_DIV),
      .SCAN_CYCLES (SCAN),
      .BLINK_CYCLES(BLINK)
   ) dut (
      .sys_clk      (clk),
      .sys_rst_n    (rst_n),
      .time_1s      (t1),
      .time_10s     (t10),
      .time_100s    (t100),
      .time_max_flag(maxf),
      .game_over    (gover),
      .shcp         (shcp),
      .stcp         (stcp),
      .ds           (ds),
      .oe_n         (oe_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Displayed segment byte for one slot, straight from the display rules.
   function automatic logic [7:0] ref_seg(input int idx, input logic [3:0] d1,
                                          input logic [3:0] d10, input logic [3:0] d100,
                                          input logic go, input logic off);
      logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      logic [3:0] d;
      logic [7:0] s;
      d = (idx == 0) ? d1 : (idx == 1) ? d10 : d100;
      s = (d > 4'd9) ? 8'hBF : tbl[d];
      if (idx == 0 && go) s[7] = 1'b0;
`ifdef TIME_SEG_LZB_EN
      if (idx == 2 && d100 == 4'd0) s = 8'hFF;
      if (idx == 1 && d100 == 4'd0 && d10 == 4'd0) s = 8'hFF;
`endif
      if (off) s = 8'hFF;
      return s;
   endfunction

   // Reference model: edge count since reset release decides when a slot samples its inputs.
   logic [13:0] exp_q[$];
   int since_rel = 0;
   int nhigh = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         since_rel = 0;
         nhigh = 0;
         exp_q.delete();
      end else begin
         if (since_rel > 0 && since_rel % SCAN == 0) begin
            int idx;
            logic [5:0] sel;
            idx = ((since_rel / SCAN) - 1) % 3;
            sel = 6'b000001 << idx;
            exp_q.push_back({sel, ref_seg(idx, t1, t10, t100, gover,
                                          ((nhigh / BLINK) % 2) == 1)});
         end
         if (maxf) nhigh++;
         else nhigh = 0;
         since_rel++;
      end
   end

   // Monitor: reassemble frames from the serial stream, pop and compare at each latch.
   logic        p_shcp = 1'b0, p_stcp = 1'b0;
   int          nbits = 0, st_w = 0, latched = 0, total_frames = 0;
   logic [13:0] sh = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         p_shcp = 1'b0;
         p_stcp = 1'b0;
         nbits = 0;
         sh = '0;
         st_w = 0;
         latched = 0;
      end else begin
         if (shcp && !p_shcp) begin
            if (nbits == 0) check("first_bit_time", since_rel % SCAN, 3);
            sh = {sh[12:0], ds};
            nbits++;
         end
         if (stcp && !p_stcp) begin
            check("latch_time", since_rel % SCAN, 57);
            check("bit_count", nbits, 14);
            check("oe_n_before_latch", oe_n, (latched == 0));
            if (exp_q.size() == 0) begin
               check("frame_expected", 0, 1);
            end else begin
               check("frame", sh, exp_q.pop_front());
            end
            nbits = 0;
            st_w = 0;
            total_frames++;
         end
         if (stcp) st_w++;
         if (!stcp && p_stcp) begin
            check("stcp_width", st_w, CLK_DIV);
            check("oe_n_after_latch", oe_n, 0);
            latched++;
         end
         p_shcp = shcp;
         p_stcp = stcp;
      end
   end

   initial begin
      int w;
      t1 = 4'd1; t10 = 4'd2; t100 = 4'd3; maxf = 1'b0; gover = 1'b0; rst_n = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_shcp", shcp, 0);
      check("rst_stcp", stcp, 0);
      check("rst_ds", ds, 0);
      check("rst_oe_n", oe_n, 1);
      rst_n = 1'b1;
      repeat (3 * SCAN + 70) @(negedge clk);
      t1 = 4'd5; t10 = 4'd0; t100 = 4'd0;
      repeat (3 * SCAN) @(negedge clk);
      t1 = 4'hA; t10 = 4'd7; t100 = 4'd9;
      repeat (SCAN) @(negedge clk);
      gover = 1'b1; t1 = 4'd7;
      repeat (3 * SCAN) @(negedge clk);
      gover = 1'b0; maxf = 1'b1;
      repeat (1200) @(negedge clk);
      maxf = 1'b0;
      repeat (2 * SCAN) @(negedge clk);
      // Random phase: inputs change at arbitrary points, including mid-frame.
      repeat (1500) begin
         if ($urandom_range(0, 15) == 0) begin
            t1 = 4'($urandom_range(0, 15));
            t10 = 4'($urandom_range(0, 15));
            t100 = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 99) == 0) gover = ~gover;
         if ($urandom_range(0, 299) == 0) maxf = ~maxf;
         @(negedge clk);
      end
      // Reset during SHIFT.
      w = 0;
      while (!shcp && w < 500) begin
         @(negedge clk);
         w++;
      end
      check("reached_shift", shcp, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_shcp", shcp, 0);
      check("mid_rst_stcp", stcp, 0);
      check("mid_rst_ds", ds, 0);
      check("mid_rst_oe_n", oe_n, 1);
      repeat (2) @(negedge clk);
      t1 = 4'd8; t10 = 4'd6; t100 = 4'd4; gover = 1'b0; maxf = 1'b0;
      rst_n = 1'b1;
      repeat (3 * SCAN + 70) @(negedge clk);
      check("frames_seen", (total_frames >= 40), 1);
      check("queue_drained", (exp_q.size() <= 1), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
